// File: rtl/g25_switch_event_ctrl.sv
// g25_switch_event_ctrl
//
// Avalon-MM slave for the board slide switches. Raw switch levels are
// synchronised, then debounced on a programmable sample tick. Each accepted
// level change (rising or falling) latches a per-bit capture flag. Any
// captured bit that is also enabled in the mask raises irq.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 debounced, 1 divider, 2 irq mask, 3 edge capture)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (1-cycle latency, not gated by chipselect)
//   in_port     raw switch levels (asynchronous to clk)
//   irq         interrupt request, active high
//
// Register map
//   0  debounced     RO
//   1  div_reg       RW, low DIV_WIDTH bits; writing 0 stores 1 (tick every cycle)
//   2  irq_mask      RW, low WIDTH bits
//   3  edge_capture  R / write-1-to-clear; a new edge wins over a same-cycle clear

module g25_switch_event_ctrl #(
   parameter int unsigned WIDTH        = 10,
   parameter int unsigned DIV_WIDTH    = 20,
   parameter int unsigned DIV_RESET    = 50000,
   parameter int unsigned STABLE_COUNT = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   localparam logic [DIV_WIDTH-1:0] DivResetVal = DIV_WIDTH'(DIV_RESET);
   localparam logic [DIV_WIDTH-1:0] DivOne      = DIV_WIDTH'(1);
   // Last count before a disagreeing bit is accepted.
   localparam logic [2:0]           CntLast     = 3'(STABLE_COUNT - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]          sync1_q;
   logic [WIDTH-1:0]          sync_q;
   logic [DIV_WIDTH-1:0]      div_q,      div_d;
   logic [DIV_WIDTH-1:0]      tick_cnt_q, tick_cnt_d;
   logic [WIDTH-1:0][2:0]     cnt_q,      cnt_d;
   logic [WIDTH-1:0]          deb_q,      deb_d;
   logic [WIDTH-1:0]          toggle_q,   toggle_d;
   logic [WIDTH-1:0]          mask_q,     mask_d;
   logic [WIDTH-1:0]          ec_q,       ec_d;
   logic [31:0]               rd_q,       rd_d;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic                      wr_en;
   logic                      wr_div;
   logic                      wr_mask;
   logic                      wr_clr;
   logic [DIV_WIDTH-1:0]      wr_div_val;
   logic [WIDTH-1:0]          clr_bits;
   logic                      tick;

   assign wr_en      = chipselect && !write_n;
   assign wr_div     = wr_en && (address == 2'd1);
   assign wr_mask    = wr_en && (address == 2'd2);
   assign wr_clr     = wr_en && (address == 2'd3);
   assign wr_div_val = writedata[DIV_WIDTH-1:0];
   assign clr_bits   = wr_clr ? writedata[WIDTH-1:0] : '0;

   // Upper write-data bits have no destination.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   // ------------------------------------------------------------------
   // Divider register and sample tick
   // ------------------------------------------------------------------
   always_comb begin
      div_d = div_q;
      if (wr_div) begin
         // A divider of 0 would never match; treat it as 1.
         div_d = (wr_div_val == '0) ? DivOne : wr_div_val;
      end
   end

   // A divider write restarts the period and suppresses that cycle's tick.
   assign tick = !wr_div && (tick_cnt_q == (div_q - DivOne));

   always_comb begin
      if (wr_div || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + DivOne;
      end
   end

   // ------------------------------------------------------------------
   // Debounce: a bit must disagree with its debounced value on
   // STABLE_COUNT consecutive ticks before the new level is accepted.
   // ------------------------------------------------------------------
   always_comb begin
      deb_d    = deb_q;
      cnt_d    = cnt_q;
      toggle_d = '0;
      if (tick) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_q[i] == deb_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
               deb_d[i]    = ~deb_q[i];
               cnt_d[i]    = '0;
               toggle_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 3'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Interrupt mask and edge capture
   // ------------------------------------------------------------------
   always_comb begin
      mask_d = mask_q;
      if (wr_mask) begin
         mask_d = writedata[WIDTH-1:0];
      end
   end

   // toggle_q lags the debounced update by one cycle; OR-ing it in after the
   // clear makes a coincident edge win.
   assign ec_d = (ec_q & ~clr_bits) | toggle_q;

   // ------------------------------------------------------------------
   // Read mux, zero-extended to 32 bits
   // ------------------------------------------------------------------
   always_comb begin
      rd_d = '0;
      case (address)
         2'd0:    rd_d[WIDTH-1:0]     = deb_q;
         2'd1:    rd_d[DIV_WIDTH-1:0] = div_q;
         2'd2:    rd_d[WIDTH-1:0]     = mask_q;
         default: rd_d[WIDTH-1:0]     = ec_q;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync_q     <= '0;
         div_q      <= DivResetVal;
         tick_cnt_q <= '0;
         cnt_q      <= '0;
         deb_q      <= '0;
         toggle_q   <= '0;
         mask_q     <= '0;
         ec_q       <= '0;
         rd_q       <= '0;
      end else begin
         sync1_q    <= in_port;
         sync_q     <= sync1_q;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         toggle_q   <= toggle_d;
         mask_q     <= mask_d;
         ec_q       <= ec_d;
         rd_q       <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(ec_q & mask_q);

endmodule

// File: tb/tb_g25_switch_event_ctrl.sv
module tb_g25_switch_event_ctrl;

   localparam int WIDTH = 10;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic [WIDTH-1:0]  in_port;
   logic              irq;

   int n_checks = 0;
   int n_errors = 0;

   // Expected read results, pushed when a read is issued.
   logic [31:0] sb_q[$];
   logic [31:0] exp_v;
   logic [31:0] got_v;

   g25_switch_event_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   // Drives a read and pushes its expected value; returns when readdata is valid.
   task automatic issue_read(input logic [1:0] a, input logic [31:0] e);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] tbl [4];
      tbl[0] = 32'd0;
      tbl[1] = 32'd50000;
      tbl[2] = 32'd0;
      tbl[3] = 32'd0;
      reset_n = 1'b0;
      cycles(2);
      n_checks++;
      if (readdata !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_readdata: got %h want 0", readdata);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_irq: got %b want 0", irq);
      end
      reset_n = 1'b1;
      cycles(1);
      for (int i = 0; i < 4; i++) begin
         issue_read(2'(i), tbl[i]);
         got_v = readdata;
         exp_v = sb_q.pop_front();
         n_checks++;
         if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL reset_read_addr%0d: got %h want %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_debounce;
      int n;
      bit seen;
      do_write(2'd1, 32'd4);
      in_port = 10'h001;
      address = 2'd0;
      n = 0;
      seen = 1'b0;
      // Sync 2 + first tick 1..4 + 3 more ticks x4 + 1 read latency.
      for (int k = 1; k <= 30 && !seen; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (readdata[0] === 1'b1) begin
            seen = 1'b1;
            n = k;
         end
      end
      n_checks++;
      if (!seen || n < 16 || n > 19) begin
         n_errors++;
         $display("FAIL debounce_latency: seen=%0b cycles=%0d want 16..19", seen, n);
      end
      issue_read(2'd3, 32'h001);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL debounce_edge_capture: got %h want %h", got_v, exp_v);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL debounce_irq_masked: got %b want 0", irq);
      end
   endtask

   task automatic test_irq_mask;
      do_write(2'd2, 32'h001);
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL mask_irq_set: got %b want 1", irq);
      end
      issue_read(2'd2, 32'h001);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL mask_readback: got %h want %h", got_v, exp_v);
      end
      do_write(2'd3, 32'h001);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL mask_irq_clear: got %b want 0", irq);
      end
      issue_read(2'd3, 32'h000);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL mask_capture_cleared: got %h want %h", got_v, exp_v);
      end
   endtask

   task automatic test_glitch;
      // 8 cycles high at div=4 spans exactly two ticks: not enough to accept.
      in_port = 10'h009;
      cycles(8);
      in_port = 10'h001;
      cycles(30);
      issue_read(2'd0, 32'h001);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL glitch_debounced: got %h want %h", got_v, exp_v);
      end
      issue_read(2'd3, 32'h000);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL glitch_capture: got %h want %h", got_v, exp_v);
      end
      in_port = 10'h009;
      cycles(30);
      issue_read(2'd0, 32'h009);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL held_debounced: got %h want %h", got_v, exp_v);
      end
      issue_read(2'd3, 32'h008);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL held_capture: got %h want %h", got_v, exp_v);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL held_irq_unmasked_bit: got %b want 0", irq);
      end
   endtask

   task automatic test_set_wins;
      do_write(2'd1, 32'd0);
      issue_read(2'd1, 32'd1);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL div_zero_readback: got %h want %h", got_v, exp_v);
      end
      // Tick every cycle: bit 0 falling is accepted at edge 6, captured at edge 7.
      in_port = 10'h008;
      address = 2'd0;
      cycles(6);
      n_checks++;
      if (readdata[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL fast_not_early: got debounced[0]=%b want 1", readdata[0]);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL fast_irq_not_early: got %b want 0", irq);
      end
      // Clear bit 0 on the same edge that the new capture sets it.
      do_write(2'd3, 32'h001);
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL set_wins_irq: got %b want 1", irq);
      end
      issue_read(2'd0, 32'h008);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL fast_debounced: got %h want %h", got_v, exp_v);
      end
      issue_read(2'd3, 32'h009);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL set_wins_capture: got %h want %h", got_v, exp_v);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] tbl [4];
      tbl[0] = 32'd0;
      tbl[1] = 32'd50000;
      tbl[2] = 32'd0;
      tbl[3] = 32'd0;
      in_port = 10'h028;
      address = 2'd3;
      cycles(3);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'd0) begin
         n_errors++;
         $display("FAIL midreset_readdata: got %h want 0", readdata);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset_irq: got %b want 0", irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue_read(2'(i), tbl[i]);
         got_v = readdata;
         exp_v = sb_q.pop_front();
         n_checks++;
         if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL midreset_read_addr%0d: got %h want %h", i, got_v, exp_v);
         end
      end
      do_write(2'd1, 32'd0);
      cycles(10);
      issue_read(2'd0, 32'h028);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL redebounce_value: got %h want %h", got_v, exp_v);
      end
      issue_read(2'd3, 32'h028);
      got_v = readdata;
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL redebounce_capture: got %h want %h", got_v, exp_v);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      @(negedge clk);
      test_reset();
      test_debounce();
      test_irq_mask();
      test_glitch();
      test_set_wins();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/g25_switch_event_ctrl.md
Name: g25_switch_event_ctrl

Overview:
Avalon-MM slave controller for the 10 board slide switches.
- Synchronises the raw switch inputs and debounces them on a programmable sample tick.
- Captures edges per bit and raises a maskable interrupt.
- Gives software a stable, event-driven view of the switch bank in place of raw sampled reads.
- Connects to the system interconnect as a peripheral alongside the other PIO slaves.

Parameters:
WIDTH, 10, number of switch inputs (1..32)
DIV_WIDTH, 20, width of sample-tick divider register
DIV_RESET, 50000, divider reset value (1 ms tick at 50 MHz)
STABLE_COUNT, 4, consecutive disagreeing ticks required to accept a change (2..7)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
in_port  input  WIDTH  raw switch levels (asynchronous)
irq  output  1  interrupt request, active high

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous, active-low, on `reset_n`. All state clears on reset assertion regardless of `clk`.
- Reset values:
  - readdata = 0, irq = 0, sync stages = 0, debounced = 0.
  - div_reg = DIV_RESET, tick counter = 0, per-bit stability counters = 0.
  - irq_mask = 0, edge_capture = 0.
- Synchroniser: 2-flop chain per bit on in_port; sync_q is the second stage.
- Tick generator:
  - Counter runs 0..div_reg-1. tick = 1 for one cycle when counter == div_reg-1; the counter then wraps to 0.
  - A write to div_reg clears the counter in the same cycle; no tick is issued that cycle.
- Debounce, per bit i, evaluated only on tick:
  - sync_q[i] == debounced[i]: cnt[i] <= 0.
  - sync_q[i] != debounced[i] and cnt[i] == STABLE_COUNT-1: debounced[i] toggles, cnt[i] <= 0.
  - Otherwise: cnt[i] increments.
  - Effect: a change is accepted after exactly STABLE_COUNT consecutive disagreeing ticks. A bounce back to agreement restarts the count.
- Edge capture:
  - edge_capture[i] sets in the cycle after debounced[i] toggles (rising or falling).
  - Write to address 3: each writedata bit = 1 clears the corresponding capture bit.
  - Set and clear in the same cycle: set wins.
- irq = |(edge_capture & irq_mask), combinational from registers, no further latency.
- Register map (write = chipselect && !write_n, takes effect at the next clk edge):
  - 0: debounced (RO; writes ignored).
  - 1: div_reg (RW, low DIV_WIDTH bits). Writing 0 stores 1, giving a tick every cycle.
  - 2: irq_mask (RW, low WIDTH bits).
  - 3: edge_capture (read, write-1-to-clear).
- Read path: readdata is registered every cycle from the address mux, zero-extended to 32 bits, unused bits 0. Read latency is 1 cycle; chipselect does not gate the read register.
- Latency: in_port step to debounced update = 2 sync cycles + time to next tick + (STABLE_COUNT-1) further ticks. edge_capture and irq follow 1 cycle after the debounced update.
- Mid-operation reset: all counters and captures discard, debounced returns to 0. After release, a held-high switch re-debounces and produces an edge.

Test Plan:
- Reset, then read addresses 0..3 -> readdata 0, 50000, 0, 0 respectively; irq = 0.
- Write div=4; drive in_port=10'h001 steady -> debounced reads 0x001 after 2 + ≤4 + 3×4 cycles. edge_capture=0x001; irq stays 0 because mask=0.
- Write mask=0x001 with edge_capture[0] set -> irq = 1 next cycle. Write 0x001 to address 3 -> edge_capture=0, irq = 0.
- div=4, bit 3 glitch: high for 2 ticks then low -> debounced[3] never changes, edge_capture[3] stays 0. Then hold high 4 ticks -> accepted.
- Clear of bit 0 in the same cycle a new edge on bit 0 sets it -> edge_capture[0] remains 1.
- Write div=0 -> reads back 1; tick every cycle; a change is accepted 2+4 cycles after the in_port step. Assert reset_n mid-count -> all registers return to reset values immediately.
